// File: rtl/tone_i2s_out_if.sv
// Sample stream from the synth datapath into the I2S output stage.
// The upstream side drives a one-cycle valid strobe with the accumulated tone; the output stage reports FIFO space.
interface tone_i2s_out_if;
    logic        sampleValid;
    logic [31:0] tone;
    logic        sampleReady;

    modport master (
        output sampleValid,
        output tone,
        input  sampleReady
    );

    modport slave (
        input  sampleValid,
        input  tone,
        output sampleReady
    );
endinterface

// File: rtl/tone_i2s_out.sv
// Scales and saturates the per-sample tone sum to 16 bits, queues it, and plays it as mono-on-stereo I2S.
// Optional feature: define AUDIO_DITHER_EN to add LFSR dither below the truncation point.
module tone_i2s_out #(
    parameter int BCLK_DIV   = 8,
    parameter int SHIFT      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_i2s_out_if.slave smp,
    output logic          frameReq_o,
    output logic          underrun_o,
    output logic          overflow_o,
    output logic          audBclk_o,
    output logic          audDaclrck_o,
    output logic          audDacdat_o
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       bitCnt_q, bitCnt_d;
    logic             lrck_q, lrck_d;
    logic             dat_q, dat_d;
    logic [15:0]      hold_q, hold_d;
    logic             frameReq_q, frameReq_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W:0]   rdPtr_q, rdPtr_d;
    logic [15:0]      fifoMem_q [FIFO_DEPTH];

    logic             divWrap;
    logic             fallTick;
    logic             frameStart;
    logic [PTR_W:0]   fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic [31:0]      dithered;
    logic signed [31:0] shifted;
    logic [15:0]      sample;
    logic [4:0]       bitPos;
    logic [3:0]       dataIdx;

    // Full/empty are judged on start-of-cycle occupancy, so a same-cycle pop never rescues a push.
    assign divWrap    = (divCnt_q == DIV_LAST);
    assign fallTick   = divWrap && bclk_q;
    assign frameStart = fallTick && (bitCnt_q == 6'd63);
    assign fifoCount  = wrPtr_q - rdPtr_q;
    assign fifoFull   = (fifoCount == FIFO_FULL);
    assign fifoEmpty  = (fifoCount == '0);
    assign push       = smp.sampleValid && !fifoFull;
    assign pop        = frameStart && !fifoEmpty;

    assign smp.sampleReady = !fifoFull;

`ifdef AUDIO_DITHER_EN
    localparam logic [15:0] DITHER_MASK = 16'((32'd1 << SHIFT) - 32'd1);

    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] ditherSum;

    // Dither is non-negative, so only a positive tone can wrap; clamp it to the largest positive value.
    always_comb begin
        ditherSum = smp.tone + {16'b0, lfsr_q & DITHER_MASK};
        dithered  = (!smp.tone[31] && ditherSum[31]) ? 32'h7FFF_FFFF : ditherSum;
        lfsr_d    = lfsr_q;
        if (push) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dithered = smp.tone;
`endif

    always_comb begin
        shifted = $signed(dithered) >>> SHIFT;
        if (shifted > 32'sd32767) begin
            sample = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            sample = 16'h8000;
        end else begin
            sample = shifted[15:0];
        end
    end

    always_comb begin
        divCnt_d   = divWrap ? '0 : divCnt_q + DIV_W'(1);
        bclk_d     = divWrap ? ~bclk_q : bclk_q;
        bitCnt_d   = bitCnt_q;
        lrck_d     = lrck_q;
        dat_d      = dat_q;
        hold_d     = hold_q;
        bitPos     = 5'd0;
        dataIdx    = 4'd0;
        frameReq_d = frameStart;
        underrun_d = frameStart && fifoEmpty;
        overflow_d = smp.sampleValid && fifoFull;
        wrPtr_d    = wrPtr_q + (PTR_W+1)'(push);
        rdPtr_d    = rdPtr_q + (PTR_W+1)'(pop);

        if (pop) begin
            hold_d = fifoMem_q[rdPtr_q[PTR_W-1:0]];
        end

        // Data and LRCK are computed from the post-increment bit count, so they land with it on the falling edge.
        if (fallTick) begin
            bitCnt_d = bitCnt_q + 6'd1;
            lrck_d   = bitCnt_d[5];
            bitPos   = bitCnt_d[4:0];
            if (bitPos >= 5'd1 && bitPos <= 5'd16) begin
                dataIdx = 4'(5'd16 - bitPos);
                dat_d   = hold_d[dataIdx];
            end else begin
                dat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q   <= '0;
            bclk_q     <= 1'b0;
            bitCnt_q   <= 6'd0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            hold_q     <= 16'h0000;
            frameReq_q <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
        end else begin
            divCnt_q   <= divCnt_d;
            bclk_q     <= bclk_d;
            bitCnt_q   <= bitCnt_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            hold_q     <= hold_d;
            frameReq_q <= frameReq_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= sample;
        end
    end

    assign frameReq_o   = frameReq_q;
    assign underrun_o   = underrun_q;
    assign overflow_o   = overflow_q;
    assign audBclk_o    = bclk_q;
    assign audDaclrck_o = lrck_q;
    assign audDacdat_o  = dat_q;
endmodule

// File: tb/tb_tone_i2s_out.sv
// Bench for tone_i2s_out: a cycle-level reference model checks every output each cycle,
// while directed sequences decode the serial stream and compare it with hand-computed samples.
module tb_tone_i2s_out;
    localparam int BCLK_DIV   = 8;
    localparam int SHIFT      = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 128 * BCLK_DIV;
    localparam int MAX_ERRORS = 40;

    typedef struct {
        logic [31:0] tone;
        logic [15:0] expected;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sampleValid = 1'b0;
    logic [31:0] tone = 32'h0;
    logic        frameReq, underrun, overflow, audBclk, audDaclrck, audDacdat;

    int passCount  = 0;
    int checkCount = 0;
    bit finished   = 1'b0;

    tone_i2s_out_if busIf ();
    assign busIf.sampleValid = sampleValid;
    assign busIf.tone        = tone;

    tone_i2s_out #(
        .BCLK_DIV   (BCLK_DIV),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smp          (busIf),
        .frameReq_o   (frameReq),
        .underrun_o   (underrun),
        .overflow_o   (overflow),
        .audBclk_o    (audBclk),
        .audDaclrck_o (audDaclrck),
        .audDacdat_o  (audDacdat)
    );

    always #5 clk = ~clk;

    task automatic finishBench();
        if (!finished) begin
            finished = 1'b1;
            $display("%0d/%0d checks passed", passCount, checkCount);
        end
        $finish;
    endtask

    task automatic checkEq(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
        if (checkCount - passCount >= MAX_ERRORS) begin
            $display("[TB] stopping early after %0d errors", checkCount - passCount);
            finishBench();
        end
    endtask

    // Reference model: sample converted with plain integer arithmetic, FIFO as a queue,
    // and the serial position derived from elapsed cycles since reset release.
    int unsigned cyc = 0;
    logic [15:0] modelQ[$];
    logic [15:0] modelHold = 16'h0;
    logic        expFrame = 1'b0, expUnder = 1'b0, expOver = 1'b0;

    function automatic logic [15:0] convert(logic [31:0] t);
        int s;
        s = $signed(t);
        s = s >>> SHIFT;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            modelQ.delete();
            modelHold = 16'h0;
            expFrame = 1'b0;
            expUnder = 1'b0;
            expOver = 1'b0;
        end else begin
            bit fullPre, emptyPre, frameStart;
            cyc++;
            fullPre    = (modelQ.size() == FIFO_DEPTH);
            emptyPre   = (modelQ.size() == 0);
            frameStart = (cyc % FRAME) == 0;
            expFrame   = frameStart;
            expUnder   = frameStart && emptyPre;
            expOver    = sampleValid && fullPre;
            if (frameStart && !emptyPre) modelHold = modelQ.pop_front();
            if (sampleValid && !fullPre) modelQ.push_back(convert(tone));
        end
    end

    int   bitIdx, chanBit;
    logic expBclk, expLrck, expDat;
    always @(negedge clk) begin
        if (!finished) begin
            bitIdx  = (cyc / (2 * BCLK_DIV)) % 64;
            chanBit = bitIdx % 32;
            expBclk = ((cyc / BCLK_DIV) % 2) == 1;
            expLrck = bitIdx >= 32;
            expDat  = (chanBit >= 1 && chanBit <= 16) ? modelHold[16 - chanBit] : 1'b0;
            checkEq($sformatf("cycle %0d {bclk,lrck,dat,freq,under,over,ready}", cyc),
                    {25'b0, audBclk, audDaclrck, audDacdat, frameReq, underrun, overflow, busIf.sampleReady},
                    {25'b0, expBclk, expLrck, expDat, expFrame, expUnder, expOver,
                     1'(modelQ.size() < FIFO_DEPTH)});
        end
    end

    task automatic applyStimulus(logic [31:0] t);
        sampleValid = 1'b1;
        tone        = t;
        @(negedge clk);
        sampleValid = 1'b0;
    endtask

    task automatic waitFrame(string name);
        int n = 1;
        @(negedge clk);
        while (!frameReq && n < 2 * FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        if (!frameReq) checkEq({name, " frame timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitRise(string name);
        int n = 0;
        while (audBclk && n < 4 * BCLK_DIV) begin
            @(negedge clk);
            n++;
        end
        while (!audBclk && n < 4 * BCLK_DIV) begin
            @(negedge clk);
            n++;
        end
        if (!audBclk) checkEq({name, " bclk timeout"}, 32'd0, 32'd1);
    endtask

    // Starts just after a frame start; decodes the left then right channel words bit by bit.
    task automatic captureAndCompare(logic [15:0] exp, string name);
        logic [31:0] word;
        logic        chanLrck;
        for (int ch = 0; ch < 2; ch++) begin
            word     = 32'h0;
            chanLrck = 1'b0;
            for (int b = 0; b < 32; b++) begin
                waitRise(name);
                if (b == 0) chanLrck = audDaclrck;
                word = {word[30:0], audDacdat};
            end
            checkEq($sformatf("%s lrck ch%0d", name, ch), {31'b0, chanLrck}, ch);
            checkEq($sformatf("%s word ch%0d", name, ch), word, {1'b0, exp, 15'b0});
        end
    endtask

    task automatic checkOutput(logic [15:0] exp, string name);
        waitFrame(name);
        captureAndCompare(exp, name);
    endtask

    function automatic logic [31:0] randTone();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: return r;
            1: return r >> $urandom_range(4, 10);
            default: return -(r >> $urandom_range(4, 10));
        endcase
    endfunction

    initial begin
        vec_t vecs[9];
        int   n;
        vecs[0] = '{32'h0012_3000, 16'h0123, "conv 0123"};
        vecs[1] = '{32'h7FFF_FFFF, 16'h7FFF, "sat max"};
        vecs[2] = '{32'h8000_0000, 16'h8000, "sat min"};
        vecs[3] = '{32'hFFFF_F000, 16'hFFFF, "minus one"};
        vecs[4] = '{32'h07FF_FFFF, 16'h7FFF, "edge +32767"};
        vecs[5] = '{32'h0800_0000, 16'h7FFF, "edge +32768"};
        vecs[6] = '{32'hF800_0000, 16'h8000, "edge -32768"};
        vecs[7] = '{32'hF7FF_F000, 16'h8000, "edge -32769"};
        vecs[8] = '{32'h0000_0FFF, 16'h0000, "truncate"};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("reset outputs", {25'b0, frameReq, underrun, overflow, audBclk, audDaclrck,
                                  audDacdat, busIf.sampleReady}, 32'h0000_0001);

        #2 rst_n = 1'b1;
        n = 0;
        while (!audBclk && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkEq("first bclk rise", n, BCLK_DIV);
        while (!frameReq && n < FRAME + 100) begin
            @(negedge clk);
            n++;
        end
        checkEq("first frame req", n, FRAME);
        checkEq("first frame underrun", {31'b0, underrun}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].tone);
            checkOutput(vecs[i].expected, vecs[i].name);
        end

        $display("[TB] overflow sequence");
        waitFrame("ovf sync");
        for (int i = 1; i <= 5; i++) begin
            sampleValid = 1'b1;
            tone        = 32'(i) << 12;
            @(negedge clk);
            if (i == 4) checkEq("ready after 4th push", {31'b0, busIf.sampleReady}, 32'd0);
            if (i == 5) checkEq("overflow on 5th push", {31'b0, overflow}, 32'd1);
        end
        sampleValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checkOutput(16'(i), $sformatf("fifo order %0d", i));
        end

        $display("[TB] underrun sequence");
        applyStimulus(32'h0004_2000);
        checkOutput(16'h0042, "play 0042");
        waitFrame("underrun frame");
        checkEq("underrun pulse", {31'b0, underrun}, 32'd1);
        captureAndCompare(16'h0042, "repeat 0042");

        $display("[TB] random traffic");
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                sampleValid = (f % 2 == 0) ? ($urandom_range(0, 59) == 0)
                                           : ($urandom_range(0, 2999) == 0);
                tone = randTone();
                @(negedge clk);
            end
        end
        sampleValid = 1'b0;

        $display("[TB] mid-frame reset");
        waitFrame("mfr sync");
        applyStimulus(32'h0001_1000);
        applyStimulus(32'h0002_2000);
        applyStimulus(32'h0003_3000);
        repeat (20 * 2 * BCLK_DIV + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkEq("mid-frame reset outputs", {25'b0, frameReq, underrun, overflow, audBclk,
                                               audDaclrck, audDacdat, busIf.sampleReady}, 32'h0000_0001);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        captureAndCompare(16'h0000, "post-reset frame");
        waitFrame("post-reset start");
        checkEq("post-reset underrun", {31'b0, underrun}, 32'd1);

        finishBench();
    end
endmodule
